// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32 memory-access stage: funct3 size codes,
// FSM state encoding, default bus timeout and byte-lane helpers.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

  // Byte enables: base mask for the size, shifted into the addressed lane.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    byte_en = 4'b0001 << lo;
      2'd1:    byte_en = 4'b0011 << lo;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the slave can pick any lane by be.
  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    lane_rep = {4{d[7:0]}};
      2'd1:    lane_rep = {2{d[15:0]}};
      default: lane_rep = d;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// load_align: combinational extract of the addressed byte/half/word from a
// bus read word, then sign- or zero-extension selected by funct3.
module load_align import riscv_mem_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  // Shift the addressed lane down to bit 0, then extend by size and sign.
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    data    = shifted;
    case (funct3[1:0])
      2'd0:    data = funct3[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'd1:    data = funct3[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: memory stage of the non-pipelined RV32 core. One load or
// store per start over a req/gnt/rvalid bus, with timeout abort.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses complete
// without a bus request and flag misaligned; otherwise the address low bits
// are masked to the access size).
module memory_access import riscv_mem_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  input  logic [2:0]        funct3,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   load_data,
  output logic              misaligned,
  output logic              bus_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  mem_state_e      state;
  logic [7:0]      tmo_cnt;
  logic [1:0]      addr_lo_q;
  logic [2:0]      funct3_q;
  logic            is_load_q;
  logic [1:0]      lo_m;
  logic [XLEN-1:0] ld_ext;
  logic            tmo_hit;

  // Low address bits forced to the access size; a no-op for aligned accesses.
  always_comb begin
    case (funct3[1:0])
      2'd0:    lo_m = addr[1:0];
      2'd1:    lo_m = {addr[1], 1'b0};
      default: lo_m = 2'b00;
    endcase
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);

`ifdef MISALIGN_TRAP_EN
  logic mis;
  assign mis = ((funct3[1:0] == 2'd1) && addr[0]) || (funct3[1] && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  load_align #(.XLEN(XLEN)) u_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (ld_ext)
  );

  // Access FSM; all outputs registered so the bus sees glitch-free signals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_data  <= '0;
      bus_error  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      tmo_cnt    <= '0;
      addr_lo_q  <= '0;
      funct3_q   <= '0;
      is_load_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bus_error <= 1'b0;
            busy      <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
            if (is_load || is_store) begin
              addr_lo_q <= lo_m;
              funct3_q  <= funct3;
              is_load_q <= is_load;
`ifdef MISALIGN_TRAP_EN
              if (mis) begin
                misaligned <= 1'b1;
                done       <= 1'b1;
                state      <= S_DONE;
              end else
`endif
              begin
                mem_req   <= 1'b1;
                mem_we    <= is_store && !is_load;
                mem_addr  <= {addr[XLEN-1:2], 2'b00};
                mem_be    <= byte_en(funct3[1:0], lo_m);
                mem_wdata <= lane_rep(funct3[1:0], store_data);
                tmo_cnt   <= '0;
                state     <= S_REQ;
              end
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (is_load_q) begin
              state <= S_WAIT;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else if (tmo_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            bus_error <= 1'b1;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (mem_rvalid) begin
            load_data <= ld_ext;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (tmo_hit) begin
            bus_error <= 1'b1;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Table-driven bench for memory_access plus directed sequences for
// misalignment, timeout and reset-mid-access.
module tb_memory_access;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [31:0] addr = '0, store_data = '0;
  logic [2:0]  funct3 = '0;
  logic        busy, done, misaligned, bus_error, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_err = 0;
  int n_chk = 0;
  logic [31:0] exp_ld = '0;

  memory_access #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .addr(addr), .store_data(store_data), .funct3(funct3), .busy(busy), .done(done),
    .load_data(load_data), .misaligned(misaligned), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          gdly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ld, logic st, logic [31:0] a, logic [31:0] sd,
                              logic [2:0] f3, logic [31:0] rd, int gdly,
                              logic [31:0] ea, logic [3:0] eb, logic [31:0] ew,
                              logic [31:0] el);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = a; v.sdata = sd; v.f3 = f3; v.rdata = rd;
    v.gdly = gdly; v.e_addr = ea; v.e_be = eb; v.e_wdata = ew; v.e_ld = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [31:0] a,
                       input logic [31:0] sd, input logic [2:0] f3);
    @(negedge clk);
    start = 1'b1; is_load = ld; is_store = st; addr = a; store_data = sd; funct3 = f3;
    @(negedge clk);
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    int lat;
    issue(v.ld, v.st, v.addr, v.sdata, v.f3);
    lat = 1;
    if (v.ld || v.st) begin
      chk($sformatf("v%0d mem_req", idx), {31'b0, mem_req}, 32'd1);
      chk($sformatf("v%0d mem_addr", idx), mem_addr, v.e_addr);
      chk($sformatf("v%0d mem_be", idx), {28'b0, mem_be}, {28'b0, v.e_be});
      chk($sformatf("v%0d mem_we", idx), {31'b0, mem_we}, {31'b0, v.st});
      if (v.st) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
      for (int k = 0; k < v.gdly; k++) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;   // rvalid in REQ must be ignored
        @(negedge clk); lat++;
        mem_rvalid = 1'b0;
        chk($sformatf("v%0d hold req", idx), {31'b0, mem_req}, 32'd1);
        chk($sformatf("v%0d hold addr", idx), mem_addr, v.e_addr);
      end
      mem_gnt = 1'b1;
      @(negedge clk); lat++;
      mem_gnt = 1'b0;
      if (v.ld) begin
        mem_rdata = v.rdata; mem_rvalid = 1'b1;
        @(negedge clk); lat++;
        mem_rvalid = 1'b0;
        exp_ld = v.e_ld;
      end
    end
    while (!done && lat < 40) begin
      @(negedge clk); lat++;
    end
    chk($sformatf("v%0d done", idx), {31'b0, done}, 32'd1);
    chk($sformatf("v%0d latency", idx), lat,
        (v.ld || v.st) ? 32'(2 + v.gdly + (v.ld ? 1 : 0)) : 32'd1);
    chk($sformatf("v%0d load_data", idx), load_data, exp_ld);
    chk($sformatf("v%0d misaligned", idx), {31'b0, misaligned}, 32'd0);
    chk($sformatf("v%0d bus_error", idx), {31'b0, bus_error}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d done pulse", idx), {31'b0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    // ld st addr sdata f3 rdata gdly | e_addr e_be e_wdata e_ld
    vecs.push_back(mk(0, 1, 32'h100, 32'hDEADBEEF, F3_SW, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 1, 32'h103, 32'h000000A5, F3_SB, 0, 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(0, 1, 32'h102, 32'h1234BEEF, F3_SH, 0, 0, 32'h100, 4'b1100, 32'hBEEFBEEF, 0));
    vecs.push_back(mk(1, 0, 32'h202, 0, F3_LB,  32'h12803456, 0, 32'h200, 4'b0100, 0, 32'hFFFFFF80));
    vecs.push_back(mk(1, 0, 32'h202, 0, F3_LBU, 32'h12803456, 2, 32'h200, 4'b0100, 0, 32'h00000080));
    vecs.push_back(mk(1, 0, 32'h202, 0, F3_LH,  32'h12803456, 0, 32'h200, 4'b1100, 0, 32'h00001280));
    vecs.push_back(mk(0, 0, 32'h999, 0, F3_LW,  0,            0, 0,       4'b0000, 0, 0));
    vecs.push_back(mk(1, 0, 32'h200, 0, F3_LH,  32'h12348001, 0, 32'h200, 4'b0011, 0, 32'hFFFF8001));
    vecs.push_back(mk(1, 0, 32'h200, 0, F3_LHU, 32'h12348001, 0, 32'h200, 4'b0011, 0, 32'h00008001));
    vecs.push_back(mk(1, 0, 32'h304, 0, F3_LW,  32'hCAFEBABE, 1, 32'h304, 4'b1111, 0, 32'hCAFEBABE));
    vecs.push_back(mk(1, 0, 32'h301, 0, F3_LB,  32'h00007F00, 0, 32'h300, 4'b0010, 0, 32'h0000007F));
`ifndef MISALIGN_TRAP_EN
    // Misaligned accesses proceed with the low bits masked to the size.
    vecs.push_back(mk(1, 0, 32'h301, 0, F3_LW,  32'h11223344, 0, 32'h300, 4'b1111, 0, 32'h11223344));
    vecs.push_back(mk(1, 0, 32'h203, 0, F3_LH,  32'hABCD0000, 0, 32'h200, 4'b1100, 0, 32'hFFFFABCD));
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst done", {31'b0, done}, 0);
    chk("rst mem_req", {31'b0, mem_req}, 0);
    chk("rst mem_we", {31'b0, mem_we}, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_be", {28'b0, mem_be}, 0);
    chk("rst load_data", load_data, 0);
    chk("rst flags", {30'b0, misaligned, bus_error}, 0);
    rst = 1'b0;

    foreach (vecs[i]) do_txn(i, vecs[i]);

    // start while busy is ignored: store stays in REQ, no extra done later
    issue(0, 1, 32'h100, 32'h1, F3_SW);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy-start req", {31'b0, mem_req}, 1);
    chk("busy-start addr", mem_addr, 32'h100);
    mem_gnt = 1'b1; @(negedge clk); mem_gnt = 0;
    chk("busy-start done", {31'b0, done}, 1);
    repeat (2) @(negedge clk);
    chk("busy-start idle", {30'b0, busy, done}, 0);

`ifdef MISALIGN_TRAP_EN
    // Misaligned word load traps without touching the bus
    issue(1, 0, 32'h301, 0, F3_LW);
    chk("mis mem_req", {31'b0, mem_req}, 0);
    chk("mis done", {31'b0, done}, 1);
    chk("mis flag", {31'b0, misaligned}, 1);
    chk("mis load_data", load_data, exp_ld);
    @(negedge clk);
    chk("mis held", {30'b0, misaligned, done}, 32'd2);
    issue(1, 0, 32'h203, 0, F3_LH);
    chk("mis half", {30'b0, misaligned, mem_req}, 32'd2);
    @(negedge clk);
`endif

    // Timeout: gnt in cycle 4, rvalid never arrives
    issue(1, 0, 32'h400, 0, F3_LW);
    lat = 1;
    repeat (3) begin @(negedge clk); lat++; end
    mem_gnt = 1'b1; @(negedge clk); lat++; mem_gnt = 1'b0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("tmo done", {31'b0, done}, 1);
    chk("tmo bus_error", {31'b0, bus_error}, 1);
    chk("tmo load_data", load_data, exp_ld);
    chk("tmo late enough", {31'b0, (lat >= 8 && lat <= 10)}, 1);
    @(negedge clk);
    chk("tmo err held", {30'b0, bus_error, done}, 32'd2);

    // Reset mid-REQ and mid-WAIT
    issue(1, 0, 32'h500, 0, F3_LW);
    chk("rstreq pre", {31'b0, mem_req}, 1);
    rst = 1'b1; #1;
    chk("rstreq mem_req", {31'b0, mem_req}, 0);
    chk("rstreq busy", {31'b0, busy}, 0);
    @(negedge clk); rst = 1'b0;
    issue(1, 0, 32'h504, 0, F3_LW);
    mem_gnt = 1'b1; @(negedge clk); mem_gnt = 1'b0;
    chk("rstwait busy pre", {31'b0, busy}, 1);
    rst = 1'b1; #1;
    chk("rstwait busy", {31'b0, busy}, 0);
    chk("rstwait mem_req", {31'b0, mem_req}, 0);
    @(negedge clk); rst = 1'b0;
    exp_ld = '0;
    mem_rdata = 32'h55AA55AA; mem_rvalid = 1'b1;
    @(negedge clk); mem_rvalid = 1'b0;
    chk("rstwait no done", {31'b0, done}, 0);
    @(negedge clk);
    chk("rstwait discard", load_data, exp_ld);
    chk("rstwait idle", {30'b0, busy, done}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
